// File: rtl/ctr_drbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctr_drbg_pkg
//  Description : Shared widths, state encoding and seed helper for the
//                AES-256 CTR_DRBG (no derivation function) blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package ctr_drbg_pkg;

    localparam int KEYLEN   = 256;
    localparam int BLOCKLEN = 128;
    localparam int SEEDLEN  = KEYLEN + BLOCKLEN;

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        ENC1 = 3'd1,
        ENC2 = 3'd2,
        ENC3 = 3'd3,
        DONE = 3'd4
    } state_e;

    // Without a derivation function the seed material is a plain XOR.
    function automatic logic [SEEDLEN-1:0] seed_material(
        input logic [SEEDLEN-1:0] entropy,
        input logic [SEEDLEN-1:0] pers
    );
        return entropy ^ pers;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes256_encrypt.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_encrypt
//  Description : Combinational single-block AES-256 encryption with on-the-fly
//                key expansion; the S-box is computed in GF(2^8).
//  Revision    : 1.0  initial release
// ============================================================================
module aes256_encrypt
    import ctr_drbg_pkg::*;
(
    input  logic [KEYLEN-1:0]   key,
    input  logic [BLOCKLEN-1:0] pt,
    output logic [BLOCKLEN-1:0] ct
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) r[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] encrypt(
        input logic [255:0] k,
        input logic [127:0] p
    );
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [127:0] s;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        rcon = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        s = p ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r < 14; r++) begin
            s = mix_columns(shift_rows(sub_bytes(s)))
                ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return shift_rows(sub_bytes(s)) ^ {w[56], w[57], w[58], w[59]};
    endfunction

    assign ct = encrypt(key, pt);

endmodule
`default_nettype wire

// File: rtl/ctr_drbg_instantiate.sv
`default_nettype none
// ============================================================================
//  Module      : ctr_drbg_instantiate
//  Description : CTR_DRBG (AES-256, no df) instantiate: one Update pass from
//                Key=0, V=0 over entropy^personalization; one AES block/cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module ctr_drbg_instantiate
    import ctr_drbg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SEEDLEN-1:0]  entropy_input,
    input  logic [SEEDLEN-1:0]  personalization_string,
    output logic [KEYLEN-1:0]   new_key,
    output logic [BLOCKLEN-1:0] new_V,
    output logic [31:0]         reseed_counter
);

    state_e              state_q, state_d;
    logic [SEEDLEN-1:0]  seed_q;
    logic [KEYLEN-1:0]   k_q;
    logic [BLOCKLEN-1:0] v_q;
    logic [BLOCKLEN-1:0] blk1_q, blk2_q, blk3_q;
    logic [KEYLEN-1:0]   new_key_q;
    logic [BLOCKLEN-1:0] new_v_q;
    logic [31:0]         reseed_counter_q;

    logic [BLOCKLEN-1:0] w_v_inc;
    logic [BLOCKLEN-1:0] w_aes_ct;
    logic [SEEDLEN-1:0]  w_temp;

    assign w_v_inc = v_q + 128'd1;
    assign w_temp  = {blk1_q, blk2_q, blk3_q} ^ seed_q;

    // Single AES core shared by ENC1..ENC3; it always sees the incremented V.
    aes256_encrypt u_aes (
        .key (k_q),
        .pt  (w_v_inc),
        .ct  (w_aes_ct)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    state_d = ENC1;
            ENC1:    state_d = ENC2;
            ENC2:    state_d = ENC3;
            ENC3:    state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q           <= '0;
            k_q              <= '0;
            v_q              <= '0;
            blk1_q           <= '0;
            blk2_q           <= '0;
            blk3_q           <= '0;
            new_key_q        <= '0;
            new_v_q          <= '0;
            reseed_counter_q <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    seed_q <= seed_material(entropy_input, personalization_string);
                    k_q    <= '0;
                    v_q    <= '0;
                end
                ENC1: begin
                    v_q    <= w_v_inc;
                    blk1_q <= w_aes_ct;
                end
                ENC2: begin
                    v_q    <= w_v_inc;
                    blk2_q <= w_aes_ct;
                end
                ENC3: begin
                    v_q    <= w_v_inc;
                    blk3_q <= w_aes_ct;
                end
                DONE: begin
                    // Sources are frozen in DONE, so rewriting keeps outputs constant.
                    new_key_q        <= w_temp[SEEDLEN-1:BLOCKLEN];
                    new_v_q          <= w_temp[BLOCKLEN-1:0];
                    reseed_counter_q <= 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign new_key        = new_key_q;
    assign new_V          = new_v_q;
    assign reseed_counter = reseed_counter_q;

endmodule
`default_nettype wire

// File: tb/tb_ctr_drbg_instantiate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctr_drbg_instantiate
//  Description : Scoreboard bench for ctr_drbg_instantiate with a byte-level
//                AES-256 / CTR_DRBG reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctr_drbg_instantiate;

    logic         clk;
    logic         rst;
    logic [383:0] entropy;
    logic [383:0] pers;
    logic [255:0] new_key;
    logic [127:0] new_V;
    logic [31:0]  reseed_counter;

    int checks = 0;
    int errors = 0;
    bit [383:0] exp_q[$];
    bit [7:0]   sb [256];

    ctr_drbg_instantiate dut (
        .clk                    (clk),
        .rst                    (rst),
        .entropy_input          (entropy),
        .personalization_string (pers),
        .new_key                (new_key),
        .new_V                  (new_V),
        .reseed_counter         (reseed_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [415:0] got, logic [415:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic void build_sbox();
        bit [7:0] p = 8'h01;
        bit [7:0] q = 8'h01;
        bit [7:0] x;
        sb[0] = 8'h63;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
    endfunction

    function automatic bit [7:0] xt(bit [7:0] a);
        return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit [127:0] ref_aes(bit [255:0] key, bit [127:0] pt);
        bit [7:0] rk [240];
        bit [7:0] s [16];
        bit [7:0] t [16];
        bit [7:0] tmp [4];
        bit [7:0] rcon [7];
        bit [7:0] x;
        bit [127:0] res;
        rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
        for (int i = 0; i < 32; i++) rk[i] = key[255-8*i -: 8];
        for (int i = 32; i < 240; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = rk[i-4+j];
            if (i % 32 == 0) begin
                x      = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rcon[i/32-1];
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[x];
            end else if (i % 32 == 16) begin
                for (int j = 0; j < 4; j++) tmp[j] = sb[tmp[j]];
            end
            for (int j = 0; j < 4; j++) rk[i+j] = rk[i-32+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[i];
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i + 4*(i%4)) % 16]];
            if (r < 14) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Update from Key=0, V=0: three counter blocks XORed with the seed material.
    function automatic bit [383:0] ref_instantiate(bit [383:0] e, bit [383:0] p);
        bit [255:0] k = '0;
        bit [127:0] v = '0;
        bit [383:0] temp;
        for (int i = 0; i < 3; i++) begin
            v = v + 1;
            temp[383-128*i -: 128] = ref_aes(k, v);
        end
        return temp ^ (e ^ p);
    endfunction

    function automatic bit [383:0] rand384();
        bit [383:0] r;
        for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- stimulus (called at a negedge) ----------------
    task automatic run(input bit [383:0] e, input bit [383:0] p, input int hold);
        entropy = e;
        pers    = p;
        exp_q.push_back(ref_instantiate(e, p));
        rst = 1'b0;
        repeat (hold) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit [383:0] e;
        bit [383:0] p;
        rst     = 1'b1;
        entropy = '0;
        pers    = '0;
        build_sbox();
        check("model_kat",
              416'(ref_aes(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                           128'h00112233445566778899aabbccddeeff)),
              416'(128'h8ea2b7ca516745bfeafc49904b496089));
        repeat (2) @(negedge clk);

        run(384'hF1A2_B3C4_D5E6_F7E8_A1B2_C3D4_E5F6_A7B8_C1D2_E3F4_A5B6,
            384'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0, 8);
        run('0, '0, 8);

        e = rand384();
        p = rand384();
        run(e, p, 7);
        run(e ^ p, '0, 7);
        run({384{1'b1}}, {384{1'b1}}, 7);

        // Inputs change right after the LOAD edge; result must reflect LOAD-time values.
        e = rand384();
        p = rand384();
        entropy = e;
        pers    = p;
        exp_q.push_back(ref_instantiate(e, p));
        rst = 1'b0;
        @(negedge clk);
        entropy = rand384();
        pers    = rand384();
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Abort during ENC2, then a full run with fresh inputs.
        entropy = rand384();
        pers    = rand384();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run(rand384(), rand384(), 8);

        run(rand384(), rand384(), 105);

        for (int i = 0; i < 5; i++) run(rand384(), rand384(), 5 + (i % 3));

        @(negedge clk);
        check("queue_drain", 416'(exp_q.size()), 416'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- monitor ----------------
    initial begin
        int         cyc;
        bit         armed;
        bit         rs;
        bit [383:0] last;
        cyc   = 0;
        armed = 1'b0;
        last  = '0;
        forever begin
            @(posedge clk);
            rs = rst;
            #1;
            if (rs) begin
                armed = 1'b1;
                cyc   = 0;
                check("reset_state", {new_key, new_V, reseed_counter}, 416'd0);
            end else if (armed) begin
                cyc++;
                if (cyc < 5) begin
                    check("busy_zero", {new_key, new_V, reseed_counter}, 416'd0);
                end else if (cyc == 5) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected: got %h expected no result",
                                 {new_key, new_V, reseed_counter});
                    end else begin
                        last = exp_q.pop_front();
                        check("done_result", {new_key, new_V, reseed_counter}, {last, 32'd1});
                    end
                end else begin
                    check("done_hold", {new_key, new_V, reseed_counter}, {last, 32'd1});
                end
            end
        end
    end

endmodule
`default_nettype wire
